mem_data_arbiter: RTL and testbench
===================================

Name: mem_data_arbiter

Overview:
- Shares the data port (port B) of the unified 1K x 16 instruction/data memory between two requesters.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/program loader.
- Arbitrates one access per cycle using round-robin with an optional bounded bus lock for loader bursts.
- Drives the memory port's address, write data and save strobe, and routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- ADDR_W, 10, word address width of the data port.
- DATA_W, 16, data word width.
- MAX_LOCK, 16, maximum consecutive cycles requester 1 may hold a lock while requester 0 is requesting (range 1..255).

Ports:
- clk  in  1  clock; same clock that drives the memory data port.
- rst_n  in  1  asynchronous active-low reset.
- req_0  in  1  CPU access request.
- we_0  in  1  CPU write enable (1 = write, 0 = read).
- addr_0  in  ADDR_W  CPU address.
- wdata_0  in  DATA_W  CPU write data.
- gnt_0  out  1  CPU access accepted this cycle.
- rvalid_0  out  1  CPU read data valid.
- rdata_0  out  DATA_W  CPU read data.
- req_1, we_1, addr_1, wdata_1  in  1/1/ADDR_W/DATA_W  loader request, same meaning as requester 0.
- lock_1  in  1  loader requests exclusive ownership of the port after its current grant.
- gnt_1, rvalid_1, rdata_1  out  1/1/DATA_W  loader grant and read return.
- mem_addr  out  ADDR_W  address to the memory data port.
- mem_wdata  out  DATA_W  write data to the memory data port.
- mem_save  out  1  write enable to the memory data port.
- mem_rdata  in  DATA_W  memory data-port output, valid 1 cycle after the address is sampled.

Behaviour:

Reset (rst_n low, asynchronous):
- state = OPEN, last = 1 (requester 0 wins the first tie), lock_cnt = 0, rd_pend = 0.
- Outputs: gnt_0/1 = 0, rvalid_0/1 = 0, mem_save = 0, mem_addr = 0, mem_wdata = 0.
- A read issued in the cycle reset asserts produces no rvalid.

Grant:
- Grant is combinational in the request cycle.
- Exactly one gnt_i, or none, is high per cycle.
- mem_addr, mem_wdata and mem_save are taken from the winner; mem_save = winner's we_i.
- With no winner: mem_save = 0, and mem_addr/mem_wdata hold requester 0's values.
- A requester holds req/we/addr/wdata stable until it sees gnt; the transfer completes at the clock edge where gnt is high.

Read return:
- A granted read in cycle N gives rvalid_i = 1 in cycle N+1, with rdata_i = mem_rdata.
- rd_pend / rd_owner registers carry the read across the edge.
- A granted write produces no rvalid.
- rdata_0/1 continuously mirror mem_rdata; they are meaningful only while the matching rvalid is high.
- Back-to-back reads from either requester give a sustained 1 access per cycle.

States:
- OPEN:
  - Only one requester active: that requester wins.
  - Both active: the requester not equal to last wins; last updates to the winner on every grant.
  - If the winner is requester 1 and lock_1 = 1 at that grant: go to LOCKED, lock_cnt = 0.
- LOCKED:
  - Only requester 1 may be granted; req_0 is held off with gnt_0 = 0.
  - lock_cnt increments on each cycle req_0 = 1, saturating at MAX_LOCK.
  - lock_1 = 0 (sampled any cycle): return to OPEN at the next edge. The current cycle still belongs to requester 1.
  - lock_cnt reaches MAX_LOCK: go to FORCED at the next edge.
- FORCED:
  - Lasts one cycle.
  - If req_0 = 1, requester 0 is granted regardless of last.
  - Otherwise OPEN rules apply, but lock_1 is ignored for this grant.
  - Next state is OPEN.

Boundaries:
- The lock counter counts only cycles where req_0 is pending; an idle CPU never forces release.
- Requester 1 may deassert req_1 while LOCKED with lock_1 still high: the port stays reserved and idle.
- Writes and reads to the same address on consecutive cycles are passed through unchanged. A read issued the cycle after a write returns the new data, which is the memory's behaviour.
- Reset mid-lock returns to OPEN immediately.

Test Plan:
1. Reset release, req_0 = 1 read addr 0x005 (mem holds 0x1234) -> gnt_0 = 1 same cycle, mem_save = 0, mem_addr = 0x005; next cycle rvalid_0 = 1, rdata_0 = 0x1234, rvalid_1 = 0.
2. Both request every cycle, lock_1 = 0, for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid goes to the correct owner one cycle later.
3. req_1 write 0x3FF <= 0xBEEF, then req_0 read 0x3FF next cycle -> mem_save = 1 only in the write cycle; rdata_0 = 0xBEEF with rvalid_0.
4. lock_1 = 1 with req_0 continuously high, MAX_LOCK = 4 -> gnt_1 for the grant cycle plus 4 LOCKED cycles, then gnt_0 = 1 in the FORCED cycle, then round-robin resumes.
5. LOCKED with req_0 = 0 for 40 cycles -> no forced release; lock_1 falls -> OPEN next edge, and a pending req_0 is granted.
6. Assert rst_n = 0 in the cycle after a granted read -> rvalid_0/1 = 0 immediately; state OPEN; the first tie after release goes to requester 0.

Source files
------------

// File: rtl/mem_data_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_arbiter_if
// Description : Bundle of requester, grant/read-return and memory data-port
//               signals shared between the arbiter and its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_data_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) ();
  // Requester 0: CPU load/store unit
  logic              req_0;
  logic              we_0;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] wdata_0;
  logic              gnt_0;
  logic              rvalid_0;
  logic [DATA_W-1:0] rdata_0;
  // Requester 1: debug / program loader
  logic              req_1;
  logic              we_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_1;
  logic              lock_1;
  logic              gnt_1;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata_1;
  // Memory data port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_save;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  req_0, we_0, addr_0, wdata_0,
    input  req_1, we_1, addr_1, wdata_1, lock_1,
    input  mem_rdata,
    output gnt_0, rvalid_0, rdata_0,
    output gnt_1, rvalid_1, rdata_1,
    output mem_addr, mem_wdata, mem_save
  );

  // Requesters and memory side
  modport master (
    output req_0, we_0, addr_0, wdata_0,
    output req_1, we_1, addr_1, wdata_1, lock_1,
    output mem_rdata,
    input  gnt_0, rvalid_0, rdata_0,
    input  gnt_1, rvalid_1, rdata_1,
    input  mem_addr, mem_wdata, mem_save
  );
endinterface
`default_nettype wire

// File: rtl/mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_data_arbiter
// Description : Round-robin arbiter sharing the data port of the unified
//               instruction/data memory between the CPU (requester 0) and the
//               debug loader (requester 1), with a bounded loader bus lock and
//               1-cycle read-data return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_data_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_data_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FORCED = 2'd2
  } state_t;

  localparam logic [7:0] c_max_lock = 8'(MAX_LOCK);

  state_t            r_state;
  logic              r_last;      // 1: requester 1 won the most recent grant
  logic [7:0]        r_lock_cnt;  // cycles the CPU has waited under lock
  logic              r_rd_pend;
  logic              r_rd_owner;

  logic              w_sel_0;
  logic              w_sel_1;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_save;
  logic [7:0]        w_cnt_inc;

  // Winner selection for the current cycle; nothing is granted during reset
  always_comb begin
    w_sel_0 = 1'b0;
    w_sel_1 = 1'b0;
    case (r_state)
      ST_LOCKED: w_sel_1 = bus.req_1;
      ST_FORCED: begin
        w_sel_0 = bus.req_0;
        w_sel_1 = bus.req_1 & ~bus.req_0;
      end
      default: begin  // ST_OPEN
        if (bus.req_0 && bus.req_1) begin
          w_sel_0 = r_last;
          w_sel_1 = ~r_last;
        end else begin
          w_sel_0 = bus.req_0;
          w_sel_1 = bus.req_1;
        end
      end
    endcase
    if (!rst_n) begin
      w_sel_0 = 1'b0;
      w_sel_1 = 1'b0;
    end
  end

  // Memory port mux: winner's request, requester 0's values when idle
  always_comb begin
    w_addr  = bus.addr_0;
    w_wdata = bus.wdata_0;
    w_save  = w_sel_0 & bus.we_0;
    if (w_sel_1) begin
      w_addr  = bus.addr_1;
      w_wdata = bus.wdata_1;
      w_save  = bus.we_1;
    end
    if (!rst_n) begin
      w_addr  = '0;
      w_wdata = '0;
      w_save  = 1'b0;
    end
  end

  assign w_cnt_inc = (r_lock_cnt == c_max_lock) ? r_lock_cnt : r_lock_cnt + 8'd1;

  // Lock state machine, round-robin history and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OPEN;
      r_last     <= 1'b1;
      r_lock_cnt <= 8'd0;
    end else begin
      if (w_sel_0) begin
        r_last <= 1'b0;
      end else if (w_sel_1) begin
        r_last <= 1'b1;
      end
      case (r_state)
        ST_LOCKED: begin
          // Releasing the lock takes priority over the starvation count
          if (!bus.lock_1) begin
            r_state <= ST_OPEN;
          end else if (bus.req_0) begin
            r_lock_cnt <= w_cnt_inc;
            if (w_cnt_inc == c_max_lock) begin
              r_state <= ST_FORCED;
            end
          end
        end
        ST_FORCED: r_state <= ST_OPEN;
        default: begin  // ST_OPEN
          if (w_sel_1 && bus.lock_1) begin
            r_state    <= ST_LOCKED;
            r_lock_cnt <= 8'd0;
          end
        end
      endcase
    end
  end

  // Carry a granted read across the edge so its data returns to the issuer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= (w_sel_0 & ~bus.we_0) | (w_sel_1 & ~bus.we_1);
      r_rd_owner <= w_sel_1;
    end
  end

  assign bus.gnt_0     = w_sel_0;
  assign bus.gnt_1     = w_sel_1;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_save  = w_save;
  assign bus.rvalid_0  = r_rd_pend & ~r_rd_owner;
  assign bus.rvalid_1  = r_rd_pend & r_rd_owner;
  assign bus.rdata_0   = bus.mem_rdata;
  assign bus.rdata_1   = bus.mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_data_arbiter
// Description : Self-checking bench for mem_data_arbiter: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_data_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 16;
  localparam int MAX_LOCK = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_data_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_data_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] init_val(input int a);
    if (a == 5) return 16'h1234;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  // Memory data port: synchronous write, 1-cycle read latency
  logic [15:0] mem [0:1023];
  bit          mem_written [0:1023];
  always @(posedge clk) begin
    if (bus.mem_save) begin
      mem[bus.mem_addr]         <= bus.mem_wdata;
      mem_written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= mem_written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(int'(bus.mem_addr));
  end

  // Behavioural reference model
  logic [15:0] ref_mem [0:1023];
  int   m_last;
  bit   m_locked, m_force;
  int   m_wait;
  bit   p_valid;
  int   p_owner;
  logic [15:0] p_data;
  // Expectations for the current cycle
  int   e_win;
  logic e_gnt0, e_gnt1, e_save, e_rv0, e_rv1;
  logic [9:0]  e_addr;
  logic [15:0] e_wdata, e_rdata;

  task automatic model_reset();
    m_last = 1; m_locked = 0; m_force = 0; m_wait = 0; p_valid = 0;
  endtask

  task automatic drive(input logic r0, w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic r1, w1, input logic [9:0] a1, input logic [15:0] d1,
                       input logic l1);
    bus.req_0 = r0; bus.we_0 = w0; bus.addr_0 = a0; bus.wdata_0 = d0;
    bus.req_1 = r1; bus.we_1 = w1; bus.addr_1 = a1; bus.wdata_1 = d1;
    bus.lock_1 = l1;
  endtask

  // Move to the sampling point and compute what the DUT should show now
  task automatic cyc_begin();
    @(negedge clk);
    if (m_force)                      e_win = bus.req_0 ? 0 : (bus.req_1 ? 1 : -1);
    else if (m_locked)                e_win = bus.req_1 ? 1 : -1;
    else if (bus.req_0 && bus.req_1)  e_win = 1 - m_last;
    else if (bus.req_0)               e_win = 0;
    else if (bus.req_1)               e_win = 1;
    else                              e_win = -1;
    e_gnt0  = (e_win == 0);
    e_gnt1  = (e_win == 1);
    e_save  = (e_win == 0) ? bus.we_0 : (e_win == 1) ? bus.we_1 : 1'b0;
    e_addr  = (e_win == 1) ? bus.addr_1 : bus.addr_0;
    e_wdata = (e_win == 1) ? bus.wdata_1 : bus.wdata_0;
    e_rv0   = p_valid && p_owner == 0;
    e_rv1   = p_valid && p_owner == 1;
    e_rdata = p_data;
  endtask

  // Cross the clock edge and advance the model by one access
  task automatic cyc_end();
    logic we, l1, r0;
    logic [9:0] a;
    logic [15:0] d;
    @(posedge clk);
    l1 = bus.lock_1;
    r0 = bus.req_0;
    p_valid = 0;
    if (e_win >= 0) begin
      we = (e_win == 0) ? bus.we_0 : bus.we_1;
      a  = (e_win == 0) ? bus.addr_0 : bus.addr_1;
      d  = (e_win == 0) ? bus.wdata_0 : bus.wdata_1;
      p_valid = !we;
      p_owner = e_win;
      p_data  = ref_mem[a];
      if (we) ref_mem[a] = d;
      m_last = e_win;
    end
    if (m_force) begin
      m_force = 0;
    end else if (m_locked) begin
      if (!l1) m_locked = 0;
      else if (r0) begin
        m_wait++;
        if (m_wait >= MAX_LOCK) begin m_locked = 0; m_force = 1; end
      end
    end else if (e_win == 1 && l1) begin
      m_locked = 1;
      m_wait   = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive(1, 0, 10'h005, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    @(negedge clk);
    n_tests++; if (bus.gnt_0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0 got %b want 0", bus.gnt_0); end
    n_tests++; if (bus.mem_addr !== 10'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 000", bus.mem_addr); end
    n_tests++; if (bus.mem_save !== 1'b0) begin n_fail++; $display("FAIL rst_mem_save got %b want 0", bus.mem_save); end
    n_tests++; if (bus.rvalid_0 !== 1'b0 || bus.rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b%b want 00", bus.rvalid_0, bus.rvalid_1); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b1) begin n_fail++; $display("FAIL rd_gnt0 got %b want 1", bus.gnt_0); end
    n_tests++; if (bus.mem_save !== 1'b0) begin n_fail++; $display("FAIL rd_save got %b want 0", bus.mem_save); end
    n_tests++; if (bus.mem_addr !== 10'h005) begin n_fail++; $display("FAIL rd_addr got %h want 005", bus.mem_addr); end
    cyc_end();
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.rvalid_0 !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid0 got %b want 1", bus.rvalid_0); end
    n_tests++; if (bus.rdata_0 !== 16'h1234) begin n_fail++; $display("FAIL rd_rdata0 got %h want 1234", bus.rdata_0); end
    n_tests++; if (bus.rvalid_1 !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid1 got %b want 0", bus.rvalid_1); end
    cyc_end();
  endtask

  task automatic test_round_robin();
    int exp_w [6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 6) drive(1, 0, 10'($urandom_range(0, 1023)), 16'h0, 1, 0, 10'($urandom_range(0, 1023)), 16'h0, 0);
      else       drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0, 0);
      cyc_begin();
      if (c < 6) begin
        n_tests++; if (bus.gnt_0 !== (exp_w[c] == 0) || bus.gnt_1 !== (exp_w[c] == 1)) begin
          n_fail++; $display("FAIL rr_gnt cycle %0d got %b%b want winner %0d", c, bus.gnt_0, bus.gnt_1, exp_w[c]); end
      end
      if (c > 0) begin
        n_tests++; if (bus.rvalid_0 !== e_rv0 || bus.rvalid_1 !== e_rv1) begin
          n_fail++; $display("FAIL rr_rvalid cycle %0d got %b%b want %b%b", c, bus.rvalid_0, bus.rvalid_1, e_rv0, e_rv1); end
        n_tests++; if ((e_rv0 ? bus.rdata_0 : bus.rdata_1) !== e_rdata) begin
          n_fail++; $display("FAIL rr_rdata cycle %0d got %h want %h", c, e_rv0 ? bus.rdata_0 : bus.rdata_1, e_rdata); end
      end
      cyc_end();
    end
  endtask

  task automatic test_write_read();
    drive(0, 0, 10'h0, 16'h0, 1, 1, 10'h3FF, 16'hBEEF, 0);
    cyc_begin();
    n_tests++; if (bus.gnt_1 !== 1'b1 || bus.mem_save !== 1'b1) begin n_fail++; $display("FAIL wr_gnt_save got %b%b want 11", bus.gnt_1, bus.mem_save); end
    n_tests++; if (bus.mem_addr !== 10'h3FF || bus.mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_addr_data got %h/%h want 3ff/beef", bus.mem_addr, bus.mem_wdata); end
    cyc_end();
    drive(1, 0, 10'h3FF, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b1 || bus.mem_save !== 1'b0) begin n_fail++; $display("FAIL raw_gnt_save got %b%b want 10", bus.gnt_0, bus.mem_save); end
    cyc_end();
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.rvalid_0 !== 1'b1 || bus.rdata_0 !== 16'hBEEF) begin n_fail++; $display("FAIL raw_rdata got %b/%h want 1/beef", bus.rvalid_0, bus.rdata_0); end
    cyc_end();
  endtask

  task automatic test_lock_forced();
    int exp_w [8] = '{1, 1, 1, 1, 1, 0, 1, 0};
    drive(1, 0, 10'h010, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b1) begin n_fail++; $display("FAIL lk_pre_gnt0 got %b want 1", bus.gnt_0); end
    cyc_end();
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 10'h020, 16'h0, 1, 0, 10'h030, 16'h0, (c < 6) ? 1'b1 : 1'b0);
      cyc_begin();
      n_tests++; if (bus.gnt_0 !== (exp_w[c] == 0) || bus.gnt_1 !== (exp_w[c] == 1)) begin
        n_fail++; $display("FAIL lk_gnt cycle %0d got %b%b want winner %0d", c, bus.gnt_0, bus.gnt_1, exp_w[c]); end
      n_tests++; if (bus.gnt_0 !== e_gnt0 || bus.gnt_1 !== e_gnt1) begin
        n_fail++; $display("FAIL lk_model cycle %0d got %b%b want %b%b", c, bus.gnt_0, bus.gnt_1, e_gnt0, e_gnt1); end
      cyc_end();
    end
  endtask

  task automatic test_lock_idle();
    logic r1;
    drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h040, 16'h0, 1);
    cyc_begin();
    n_tests++; if (bus.gnt_1 !== 1'b1) begin n_fail++; $display("FAIL li_grant got %b want 1", bus.gnt_1); end
    cyc_end();
    for (int c = 0; c < 40; c++) begin
      r1 = 1'($urandom_range(0, 1));
      drive(0, 0, 10'h0, 16'h0, r1, 0, 10'($urandom_range(0, 1023)), 16'h0, 1);
      cyc_begin();
      n_tests++; if (bus.gnt_0 !== 1'b0 || bus.gnt_1 !== r1) begin
        n_fail++; $display("FAIL li_hold cycle %0d got %b%b want 0%b", c, bus.gnt_0, bus.gnt_1, r1); end
      cyc_end();
    end
    drive(1, 0, 10'h050, 16'h0, 1, 0, 10'h060, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b0 || bus.gnt_1 !== 1'b1) begin n_fail++; $display("FAIL li_release_cycle got %b%b want 01", bus.gnt_0, bus.gnt_1); end
    cyc_end();
    drive(1, 0, 10'h050, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b1) begin n_fail++; $display("FAIL li_open_gnt0 got %b want 1", bus.gnt_0); end
    cyc_end();
  endtask

  task automatic test_reset_midlock();
    drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h070, 16'h0, 1);
    cyc_begin(); cyc_end();
    drive(0, 0, 10'h0, 16'h0, 1, 0, 10'h071, 16'h0, 1);
    cyc_begin();
    n_tests++; if (bus.gnt_1 !== 1'b1) begin n_fail++; $display("FAIL rm_gnt1 got %b want 1", bus.gnt_1); end
    cyc_end();
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.rvalid_1 !== 1'b0 || bus.rvalid_0 !== 1'b0) begin n_fail++; $display("FAIL rm_rvalid got %b%b want 00", bus.rvalid_0, bus.rvalid_1); end
    n_tests++; if (bus.gnt_1 !== 1'b0) begin n_fail++; $display("FAIL rm_gnt_in_reset got %b want 0", bus.gnt_1); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(1, 0, 10'h080, 16'h0, 1, 0, 10'h081, 16'h0, 1);
    cyc_begin();
    n_tests++; if (bus.gnt_0 !== 1'b1 || bus.gnt_1 !== 1'b0) begin n_fail++; $display("FAIL rm_first_tie got %b%b want 10", bus.gnt_0, bus.gnt_1); end
    cyc_end();
  endtask

  task automatic test_random();
    logic r0, w0, r1, w1, l1;
    logic [9:0] a0, a1;
    logic [15:0] d0, d1;
    r0 = 0; r1 = 0; w0 = 0; w1 = 0; l1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 600; c++) begin
      if (!r0 || e_win == 0) begin
        r0 = ($urandom_range(0, 3) != 0); w0 = 1'($urandom_range(0, 1));
        a0 = 10'($urandom_range(0, 15)); d0 = 16'($urandom);
      end
      if (!r1 || e_win == 1) begin
        r1 = ($urandom_range(0, 2) != 0); w1 = 1'($urandom_range(0, 1));
        a1 = 10'($urandom_range(0, 15)); d1 = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) l1 = ~l1;
      drive(r0, w0, a0, d0, r1, w1, a1, d1, l1);
      cyc_begin();
      n_tests++; if (bus.gnt_0 !== e_gnt0 || bus.gnt_1 !== e_gnt1) begin
        n_fail++; $display("FAIL rnd_gnt cycle %0d got %b%b want %b%b", c, bus.gnt_0, bus.gnt_1, e_gnt0, e_gnt1); end
      n_tests++; if (bus.mem_save !== e_save || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
        n_fail++; $display("FAIL rnd_port cycle %0d got %b/%h/%h want %b/%h/%h", c, bus.mem_save, bus.mem_addr, bus.mem_wdata, e_save, e_addr, e_wdata); end
      n_tests++; if (bus.rvalid_0 !== e_rv0 || bus.rvalid_1 !== e_rv1) begin
        n_fail++; $display("FAIL rnd_rvalid cycle %0d got %b%b want %b%b", c, bus.rvalid_0, bus.rvalid_1, e_rv0, e_rv1); end
      if (e_rv0) begin
        n_tests++; if (bus.rdata_0 !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata0 cycle %0d got %h want %h", c, bus.rdata_0, e_rdata); end
      end
      if (e_rv1) begin
        n_tests++; if (bus.rdata_1 !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata1 cycle %0d got %h want %h", c, bus.rdata_1, e_rdata); end
      end
      cyc_end();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    model_reset();
    e_win = -1;
    drive(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0, 0);
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock_forced();
    test_lock_idle();
    test_reset_midlock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
